// File: rtl/aes_decrypt_scheduler.sv
// aes_decrypt_scheduler: round-robin scheduler feeding two requesters' jobs to one shared AES decipher core
module aes_decrypt_scheduler #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid_i,
    output logic         req0_ready_o,
    input  logic [7:0]   req0_nk_i,
    input  logic [127:0] req0_ct_i,
    input  logic         req1_valid_i,
    output logic         req1_ready_o,
    input  logic [7:0]   req1_nk_i,
    input  logic [127:0] req1_ct_i,
    input  logic         key_ready_i,
    output logic         core_load_o,
    output logic [7:0]   core_nk_o,
    output logic [127:0] core_ct_o,
    input  logic         core_done_i,
    input  logic [127:0] core_pt_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic         rsp_id_o,
    output logic         rsp_err_o,
    output logic [127:0] rsp_data_o,
    output logic [15:0]  jobs_done_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;
    state_t         state_q;
    logic           last_q, id_q, err_q;
    logic [7:0]     nk_q;
    logic [127:0]   ct_q, data_q;
    logic [15:0]    jobs_q;
    logic [CW-1:0]  cnt_q;
    logic           grant, accept, nk_ok;
    logic [7:0]     nk_in;
    logic [127:0]   ct_in;
    // grant selects requester 1 when it is alone or when requester 0 was served last
    always_comb begin
        grant = (req0_valid_i & req1_valid_i) ? ~last_q : req1_valid_i;
        req0_ready_o = ~reset & (state_q == IDLE) & key_ready_i & req0_valid_i & ~grant;
        req1_ready_o = ~reset & (state_q == IDLE) & key_ready_i & req1_valid_i & grant;
        accept = (req0_valid_i & req0_ready_o) | (req1_valid_i & req1_ready_o);
        nk_in = grant ? req1_nk_i : req0_nk_i;
        ct_in = grant ? req1_ct_i : req0_ct_i;
        nk_ok = (nk_in == 8'd4) | (nk_in == 8'd6) | (nk_in == 8'd8);
    end
    assign core_load_o = state_q == LOAD;
    assign rsp_valid_o = state_q == RESP;
    assign core_nk_o   = nk_q;
    assign core_ct_o   = ct_q;
    assign rsp_id_o    = id_q;
    assign rsp_err_o   = err_q;
    assign rsp_data_o  = data_q;
    assign jobs_done_o = jobs_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
            nk_q    <= '0;
            ct_q    <= '0;
            data_q  <= '0;
            jobs_q  <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    last_q  <= grant;
                    id_q    <= grant;
                    nk_q    <= nk_in;
                    ct_q    <= ct_in;
                    err_q   <= ~nk_ok;
                    data_q  <= '0;
                    state_q <= nk_ok ? LOAD : RESP;
                end
                LOAD: begin
                    cnt_q   <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (core_done_i) begin
                        data_q  <= core_pt_i;
                        err_q   <= 1'b0;
                        state_q <= RESP;
                    end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        data_q  <= '0;
                        err_q   <= 1'b1;
                        state_q <= RESP;
                    end
                end
                RESP: if (rsp_ready_i) begin
                    jobs_q  <= jobs_q + 16'd1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_decrypt_scheduler.sv
// tb_aes_decrypt_scheduler: directed stimulus with a transaction-level scheduler model and an emulated decipher core
module tb_aes_decrypt_scheduler;
    localparam int TO = 64;
    localparam logic [127:0] AES_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] AES_PT = 128'h00112233445566778899aabbccddeeff;
    logic clk = 1'b0, reset = 1'b1;
    logic v0 = 0, v1 = 0, r0, r1, key = 1, rsp_ready = 1;
    logic [7:0] nk0 = 0, nk1 = 0, core_nk;
    logic [127:0] ct0 = 0, ct1 = 0, core_ct, core_pt, rsp_data;
    logic core_load, core_done, rsp_valid, rsp_id, rsp_err;
    logic [15:0] jobs;
    int total = 0, bad = 0;
    int done_run = 5;
    int ridx = 1000;
    always #5 clk = ~clk;
    aes_decrypt_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req0_valid_i(v0), .req0_ready_o(r0), .req0_nk_i(nk0), .req0_ct_i(ct0),
        .req1_valid_i(v1), .req1_ready_o(r1), .req1_nk_i(nk1), .req1_ct_i(ct1),
        .key_ready_i(key), .core_load_o(core_load), .core_nk_o(core_nk), .core_ct_o(core_ct),
        .core_done_i(core_done), .core_pt_i(core_pt),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_err_o(rsp_err), .rsp_data_o(rsp_data), .jobs_done_o(jobs)
    );
    function automatic logic [127:0] pt_for(input logic [127:0] ct);
        return ct == AES_CT ? AES_PT : ct ^ {4{32'hdeadbeef}};
    endfunction
    // emulated core: done is sticky while idle and during the load cycle, then rises at RUN index done_run
    always @(posedge clk) begin
        #1;
        if (core_load) ridx = -1;
        else if (ridx < 1000) ridx++;
    end
    assign core_done = (ridx == -1) || (ridx >= done_run);
    assign core_pt = pt_for(core_ct);
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask
    // transaction-level model: one job in flight, response time derived from acceptance cycle
    int cyc = 0, m_acc = 0, m_rsp_at = 0, fin;
    logic m_busy = 0, m_last = 1, m_id = 0, m_err = 0, m_legal = 0;
    logic [7:0] m_nk = 0;
    logic [127:0] m_ct = 0, m_data = 0;
    logic [15:0] m_jobs = 0;
    logic e_r0, e_r1, e_load, e_rv;
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            m_busy = 0; m_last = 1; m_jobs = 0; m_nk = 0; m_ct = 0;
            chk("rst_r0", r0, 0); chk("rst_r1", r1, 0); chk("rst_load", core_load, 0);
            chk("rst_valid", rsp_valid, 0); chk("rst_err", rsp_err, 0); chk("rst_data", rsp_data, 0);
            chk("rst_id", rsp_id, 0); chk("rst_jobs", jobs, 0); chk("rst_nk", core_nk, 0); chk("rst_ct", core_ct, 0);
        end else begin
            e_r0 = !m_busy && key && v0 && (!v1 || m_last);
            e_r1 = !m_busy && key && v1 && (!v0 || !m_last);
            e_load = m_busy && m_legal && cyc == m_acc + 1;
            e_rv = m_busy && cyc >= m_rsp_at;
            chk("m_r0", r0, e_r0); chk("m_r1", r1, e_r1); chk("m_load", core_load, e_load);
            chk("m_valid", rsp_valid, e_rv); chk("m_jobs", jobs, m_jobs);
            chk("m_nk", core_nk, m_nk); chk("m_ct", core_ct, m_ct);
            if (e_rv) begin
                chk("m_id", rsp_id, m_id); chk("m_err", rsp_err, m_err); chk("m_data", rsp_data, m_data);
            end
            if (e_rv && rsp_ready) begin
                m_busy = 0; m_jobs++;
            end else if (e_r0 || e_r1) begin
                m_busy = 1; m_acc = cyc; m_id = e_r1; m_last = e_r1;
                m_nk = e_r1 ? nk1 : nk0; m_ct = e_r1 ? ct1 : ct0;
                m_legal = m_nk == 4 || m_nk == 6 || m_nk == 8;
                if (!m_legal) begin
                    m_rsp_at = cyc + 1; m_err = 1; m_data = 0;
                end else begin
                    fin = done_run < TO ? done_run : TO - 1;
                    m_rsp_at = cyc + 3 + fin;
                    m_err = done_run > TO - 1;
                    m_data = m_err ? 128'h0 : pt_for(m_ct);
                end
            end
        end
    end
    task automatic tick(); @(posedge clk); #1; endtask
    task automatic mid(); @(negedge clk); endtask
    task automatic wait_valid(input int lim, output int n);
        n = 0;
        while (!rsp_valid && n < lim) begin tick(); mid(); n++; end
        chk("rsp_wait", rsp_valid, 1);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        int n;
        int g[$], r[$];
        logic [3:0] gs, rs;
        int drs[2] = '{63, 64};
        logic [127:0] d0;
        repeat (3) tick();
        mid(); chk("init_jobs", jobs, 0); chk("init_valid", rsp_valid, 0);
        tick(); reset = 0;
        // basic AES-128 job
        tick(); v0 = 1; nk0 = 4; ct0 = AES_CT; done_run = 5;
        mid(); chk("aes_ready0", r0, 1);
        tick(); v0 = 0;
        mid(); chk("aes_load", core_load, 1);
        wait_valid(20, n); chk("aes_lat", n, 7);
        chk("aes_data", rsp_data, AES_PT); chk("aes_id", rsp_id, 0); chk("aes_err", rsp_err, 0);
        tick(); mid(); chk("aes_jobs", jobs, 1);
        // illegal Nk on requester 1
        tick(); v1 = 1; nk1 = 5; ct1 = 128'h1234;
        mid(); chk("ill_ready1", r1, 1);
        tick(); v1 = 0;
        mid(); chk("ill_valid", rsp_valid, 1); chk("ill_err", rsp_err, 1); chk("ill_data", rsp_data, 0);
        chk("ill_id", rsp_id, 1); chk("ill_load", core_load, 0);
        tick(); mid(); chk("ill_jobs", jobs, 2);
        // contention straight out of reset
        tick(); reset = 1;
        tick(); reset = 0; v0 = 1; v1 = 1; nk0 = 4; nk1 = 6; ct0 = 128'haaaa; ct1 = 128'hbbbb; done_run = 2;
        for (int i = 0; i < 200 && r.size() < 4; i++) begin
            mid();
            if (r0) g.push_back(0);
            if (r1) g.push_back(1);
            if (rsp_valid) r.push_back(int'(rsp_id));
            tick();
        end
        v0 = 0; v1 = 0;
        chk("rr_ngrant", g.size() >= 4, 1); chk("rr_nrsp", r.size(), 4);
        gs = 4'hf; rs = 4'hf;
        for (int i = 0; i < 4; i++) begin
            if (i < g.size()) gs[3-i] = g[i][0];
            if (i < r.size()) rs[3-i] = r[i][0];
        end
        chk("rr_grants", gs, 4'b0101); chk("rr_ids", rs, 4'b0101);
        // done on the last allowed RUN cycle succeeds, one later times out
        for (int k = 0; k < 2; k++) begin
            tick(); v0 = 1; nk0 = 8; ct0 = 128'hc0ffee + k; done_run = drs[k];
            mid(); chk("to_ready0", r0, 1);
            tick(); v0 = 0;
            mid(); wait_valid(100, n); chk("to_lat", n, 65);
            chk("to_err", rsp_err, k == 1);
            chk("to_data", rsp_data, k == 1 ? 128'h0 : pt_for(128'hc0ffee));
        end
        // backpressure with key_ready dropped mid-job
        tick(); v0 = 1; nk0 = 6; ct0 = 128'h5555; done_run = 1; rsp_ready = 0;
        mid(); chk("bp_ready0", r0, 1);
        tick(); v0 = 0; key = 0;
        mid(); wait_valid(20, n);
        d0 = rsp_data;
        chk("bp_data", d0, 128'h5555 ^ {4{32'hdeadbeef}});
        for (int i = 0; i < 10; i++) begin
            tick(); v0 = 1; v1 = 1; key = 1;
            mid(); chk("bp_valid", rsp_valid, 1); chk("bp_r0", r0, 0); chk("bp_r1", r1, 0);
            chk("bp_hold", rsp_data, d0); chk("bp_id", rsp_id, 0);
        end
        tick(); v0 = 0; v1 = 0; rsp_ready = 1;
        mid(); tick(); mid(); chk("bp_drop", rsp_valid, 0); chk("bp_jobs", jobs, 7);
        // key gating, then reset during RUN, then a fresh job
        tick(); key = 0; v0 = 1; nk0 = 4; ct0 = AES_CT; done_run = 3;
        for (int i = 0; i < 5; i++) begin mid(); chk("kg_r0", r0, 0); tick(); end
        key = 1;
        mid(); chk("kg_open", r0, 1);
        tick(); v0 = 0;
        mid(); chk("kg_load", core_load, 1);
        tick(); reset = 1;
        mid(); chk("mr_jobs", jobs, 0); chk("mr_valid", rsp_valid, 0); chk("mr_ct", core_ct, 0);
        chk("mr_nk", core_nk, 0); chk("mr_load", core_load, 0);
        tick(); reset = 0; v0 = 1; done_run = 2;
        mid(); chk("pr_ready0", r0, 1);
        tick(); v0 = 0;
        mid(); wait_valid(20, n); chk("pr_lat", n, 4);
        chk("pr_data", rsp_data, AES_PT); chk("pr_err", rsp_err, 0);
        tick(); mid(); chk("pr_jobs", jobs, 1);
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
